// File: rtl/ram256x64_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram256x64_arbiter
// Purpose : Two-requester round-robin arbiter/sequencer for one RAM256x64.
// Revision: 1.0 - initial release
// ============================================================================
module ram256x64_arbiter #(
  parameter int DEPTH = 226,
  parameter int AW    = 8,
  parameter int DW    = 64
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_in,
  output logic          ram_write,
  input  logic [DW-1:0] ram_out
);

  localparam logic [AW:0] c_DEPTH_LIM = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          sel_q, sel_d;
  logic          oor_q, oor_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [AW-1:0] ram_address_q, ram_address_d;
  logic [DW-1:0] ram_in_q, ram_in_d;
  logic          ram_write_q, ram_write_d;

  logic          w_pick;
  logic [AW-1:0] w_addr;
  logic          w_oor;
  logic          w_we;

  // Requester 1 wins when alone, or when both request and 0 went last.
  assign w_pick = req1 & (~req0 | ~last_q);
  assign w_addr = w_pick ? addr1 : addr0;
  assign w_we   = w_pick ? we1 : we0;
  assign w_oor  = ({1'b0, w_addr} >= c_DEPTH_LIM);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      sel_q         <= 1'b0;
      oor_q         <= 1'b0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      ram_address_q <= '0;
      ram_in_q      <= '0;
      ram_write_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      sel_q         <= sel_d;
      oor_q         <= oor_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
      ram_address_q <= ram_address_d;
      ram_in_q      <= ram_in_d;
      ram_write_q   <= ram_write_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    sel_d         = sel_q;
    oor_d         = oor_q;
    gnt0_d        = 1'b0;
    gnt1_d        = 1'b0;
    rvalid0_d     = 1'b0;
    rvalid1_d     = 1'b0;
    err_d         = err_q;
    rdata_d       = rdata_q;
    ram_address_d = ram_address_q;
    ram_in_d      = ram_in_q;
    ram_write_d   = 1'b0;

    case (state_q)
      ACCESS: begin
        // RAM word was loaded at the falling edge inside this cycle.
        state_d   = RESP;
        rvalid0_d = ~sel_q;
        rvalid1_d = sel_q;
        err_d     = oor_q;
        rdata_d   = oor_q ? '0 : ram_out;
      end
      default: begin
        if (req0 || req1) begin
          state_d       = ACCESS;
          sel_d         = w_pick;
          gnt0_d        = ~w_pick;
          gnt1_d        = w_pick;
          oor_d         = w_oor;
          ram_address_d = w_addr;
          ram_in_d      = w_pick ? wdata1 : wdata0;
          ram_write_d   = w_we & ~w_oor;
          if (req0 && req1) begin
            last_d = w_pick;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign ram_address = ram_address_q;
  assign ram_in      = ram_in_q;
  assign ram_write   = ram_write_q;

endmodule
`default_nettype wire

// File: tb/tb_ram256x64_arbiter.sv
`default_nettype none
// Testbench for ram256x64_arbiter: falling-edge RAM model plus response scoreboard.
module tb_ram256x64_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0, we0, req1, we1;
  logic [7:0]  addr0, addr1;
  logic [63:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err, ram_write;
  logic [63:0] rdata, ram_in, ram_out;
  logic [7:0]  ram_address;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        r;
    logic        err;
    logic [63:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic [63:0] mem [0:225];
  logic [63:0] sh  [0:255];

  ram256x64_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .err(err), .ram_address(ram_address), .ram_in(ram_in),
    .ram_write(ram_write), .ram_out(ram_out)
  );

  always #5 clock = ~clock;

  // RAM256x64 with only words 0..225 implemented, sampled on the falling edge.
  always @(negedge clock) begin
    if (ram_address < 8'd226) begin
      ram_out <= mem[ram_address];
      if (ram_write) mem[ram_address] <= ram_in;
    end else begin
      ram_out <= 'x;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: every rvalid must match the head of the scoreboard.
  always begin
    @(posedge clock);
    #1;
    if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
      chk("rvalid_excl", {63'd0, rvalid0 & rvalid1}, 64'd0);
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL resp_unexpected observed=rvalid0:%b rvalid1:%b expected=none", rvalid0, rvalid1);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_who", {63'd0, rvalid1}, {63'd0, mon_e.r});
        chk("resp_err", {63'd0, err}, {63'd0, mon_e.err});
        chk("resp_rdata", rdata, mon_e.data);
      end
    end
  end

  task automatic push_exp(input logic r, input logic we, input logic [7:0] a, input logic [63:0] d);
    exp_t e;
    e.r    = r;
    e.err  = (a >= 8'd226);
    e.data = e.err ? 64'd0 : sh[a];
    sb.push_back(e);
    if (we && !e.err) sh[a] = d;
  endtask

  task automatic cmd(input logic r, input logic we, input logic [7:0] a, input logic [63:0] d);
    bit got = 0;
    logic g;
    @(negedge clock);
    if (r) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    push_exp(r, we, a, d);
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clock);
      #1;
      g = r ? gnt1 : gnt0;
      if (g === 1'b1) got = 1;
    end
    req0 = 0;
    req1 = 0;
    chk("gnt_seen", {63'd0, got}, 64'd1);
    if (!got) begin
      void'(sb.pop_back());
    end else begin
      chk("gnt_other", {63'd0, r ? gnt0 : gnt1}, 64'd0);
      chk("access_we", {63'd0, ram_write}, {63'd0, we && (a < 8'd226)});
      chk("access_addr", {56'd0, ram_address}, {56'd0, a});
      @(posedge clock);
      #1;
      chk("latency_rvalid", {63'd0, r ? rvalid1 : rvalid0}, 64'd1);
      chk("gnt_pulse", {62'd0, gnt1, gnt0}, 64'd0);
      chk("resp_we_low", {63'd0, ram_write}, 64'd0);
    end
  endtask

  initial begin
    bit got;
    reset_n = 0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) begin
      sh[i] = 64'h0123_4567_0000_0000 | 64'(i);
      if (i < 226) mem[i] = sh[i];
    end
    @(posedge clock);
    #1;
    chk("rst_outs", {56'd0, gnt0, gnt1, rvalid0, rvalid1, err, ram_write, 2'b00}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_ram_addr", {56'd0, ram_address}, 64'd0);
    chk("rst_ram_in", ram_in, 64'd0);
    @(negedge clock);
    reset_n = 1;

    // Contention straight after reset: 0 first, then alternate every 2 cycles.
    @(negedge clock);
    req0 = 1; we0 = 0; addr0 = 8'd20;
    req1 = 1; we1 = 0; addr1 = 8'd21;
    push_exp(0, 0, 8'd20, 64'd0);
    push_exp(1, 0, 8'd21, 64'd0);
    push_exp(0, 0, 8'd20, 64'd0);
    push_exp(1, 0, 8'd21, 64'd0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock);
      #1;
      chk("rr_gnt0", {63'd0, gnt0}, {63'd0, (k % 4) == 1});
      chk("rr_gnt1", {63'd0, gnt1}, {63'd0, (k % 4) == 3});
    end
    req0 = 0;
    req1 = 0;
    @(posedge clock);

    cmd(0, 1, 8'd5, 64'hDEAD_BEEF_0000_0001);
    cmd(0, 0, 8'd5, 64'd0);
    chk("read_back5", rdata, 64'hDEAD_BEEF_0000_0001);
    cmd(0, 1, 8'd7, 64'hA);
    cmd(0, 1, 8'd7, 64'hB);
    chk("prewrite7", rdata, 64'hA);
    cmd(1, 0, 8'd7, 64'd0);
    chk("read_back7", rdata, 64'hB);

    cmd(1, 0, 8'd226, 64'd0);
    cmd(1, 1, 8'd255, 64'hFFFF_FFFF_FFFF_FFFF);
    cmd(0, 0, 8'd225, 64'd0);
    chk("oor_225_intact", rdata, 64'h0123_4567_0000_00E1);

    // Reset during ACCESS of a write: the write must never land.
    @(negedge clock);
    req0 = 1; we0 = 1; addr0 = 8'd9; wdata0 = 64'hBAD0_BAD0_BAD0_BAD0;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clock);
      #1;
      if (gnt0 === 1'b1) got = 1;
    end
    chk("rst_gnt_seen", {63'd0, got}, 64'd1);
    chk("rst_pre_we", {63'd0, ram_write}, 64'd1);
    reset_n = 0;
    req0 = 0;
    #1;
    chk("rst_async_we", {63'd0, ram_write}, 64'd0);
    chk("rst_async_gnt", {63'd0, gnt0}, 64'd0);
    @(posedge clock);
    #1;
    chk("rst_no_rvalid", {62'd0, rvalid1, rvalid0}, 64'd0);
    @(negedge clock);
    reset_n = 1;
    @(posedge clock);
    #1;
    chk("rst_no_rvalid2", {62'd0, rvalid1, rvalid0}, 64'd0);
    cmd(0, 0, 8'd9, 64'd0);
    chk("rst_addr9_old", rdata, 64'h0123_4567_0000_0009);

    @(posedge clock);
    #2;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
